seven_segment_decoder: RTL and testbench
========================================

# seven_segment_decoder

Receive-side counterpart of the seven-segment display driver. It watches a multiplexed 8-digit, active-low anode/cathode bus and rebuilds the 32-bit hex value being displayed, one nibble per digit. The team uses it as an on-chip loopback monitor for the display path and to read external multiplexed displays back into the design. Each capture is qualified by a settle filter, so ghosting during digit transitions is never sampled.

## Interface
- SETTLE_CYCLES, default 16: consecutive stable cycles of the synchronized bus required before a digit is sampled; legal range 1..65535.
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- cat_in  input  7  cathodes, active-low; bit0 = segment a … bit6 = segment g.
- an_in  input  8  anodes, active-low; bit k low selects digit k, which carries nibble [4k+3:4k].
- val_out  output  32  last complete reconstructed value.
- valid_out  output  1  one-cycle pulse when val_out is updated.
- err_out  output  1  one-cycle pulse on an illegal bus state; the frame is discarded.
- digit_mask_out  output  8  digits captured so far in the current frame.

## Operation
- Both buses pass through a 2-flop synchronizer. The synchronizer reset value is all-ones.
- Settle counter:
  - Clears on any change of the synchronized {an, cat}.
  - Increments while the bus is stable and saturates at SETTLE_CYCLES.
- FSM:
  - WAIT → SAMPLE when the stable count reaches SETTLE_CYCLES.
  - SAMPLE → DONE unconditionally.
  - DONE → WAIT on any bus change.
  - Exactly one sample is taken per stable period.
- Sample evaluation, with s = ~cat:
  - an == 8'hFF (blank): nothing is recorded and there is no error.
  - More than one anode bit low: err_out pulses and digit_mask is cleared.
  - Exactly one anode bit k low: s is decoded against the legal patterns below.
- Legal patterns s[6:0] → nibble: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F.
- Any other s value: err_out pulses and digit_mask is cleared.
- Legal s value: write the nibble into shadow[4k+3:4k] and set mask bit k.
- Recapturing an already-set digit overwrites its nibble; the mask is unchanged.
- Frame completion: when a legal sample makes the mask 8'hFF:
  - val_out receives the shadow register including the new nibble.
  - valid_out pulses.
  - The mask clears in the same edge.
- Digit order is irrelevant. No timeout applies; a partial frame persists indefinitely.
- val_out holds its value between frames. Errors never modify val_out.

## Timing
- Let E0 be the first rising edge that samples new pin values.
- If the pins stay constant through edge E0+SETTLE_CYCLES+2, then the capture, the mask update, val_out, valid_out and err_out all register on that edge.
- valid_out and err_out are high for exactly the following cycle.
- A bus change before that edge restarts the settle count from the new E0, and nothing is captured.
- A bus change after capture re-arms the FSM; a new stable period samples again.
- valid_out and err_out are mutually exclusive, and each is at most one cycle wide per sample.
- Reset, asserted asynchronously at any time, including mid-frame:
  - val_out = 0, valid_out = 0, err_out = 0, digit_mask_out = 0, shadow = 0.
  - Settle counter = 0, FSM = WAIT, synchronizers = all-ones.
- After reset deasserts, outputs stay at their reset values until a full new frame of 8 digits is captured.
- The block accepts dwell times ≥ SETTLE_CYCLES+3 cycles. Shorter dwells produce no captures and no errors.

## Test plan
- **Full frame.** SETTLE_CYCLES=16; drive digits 0..7 for value 0x1234ABCD with 50-cycle dwell each → one valid_out pulse after digit 7, val_out=0x1234ABCD, err_out never high, digit_mask_out back to 0.
- **Glitch reject.** A 5-cycle anode glitch to digit 3 inside a digit-2 dwell → no capture for digit 3. Digit 2 is resampled after the glitch with its value unchanged, and no err_out.
- **Illegal segments.** Capture 4 digits, then an=8'hF7 with cat=7'h7F (s=0, blank segments) held 30 cycles → one err_out pulse, mask=0. A following clean frame of 0xFFFF0000 gives val_out=0xFFFF0000.
- **Multi-hot anode.** an=8'hFC held 30 cycles → one err_out pulse, mask cleared, val_out unchanged.
- **Reset mid-frame.** Capture 5 digits, assert rst_in low asynchronously → all outputs 0 immediately. Drive 3 more digits → no valid_out. A full 8-digit frame then gives valid_out.
- **Latency.** SETTLE_CYCLES=1; drive digit 0 with cat encoding 'A' (s=77) at E0 → digit_mask_out[0] and the capture appear on edge E0+3, and a complete frame's valid_out is high in the cycle after E0+3.

Source files
------------

// File: rtl/seven_segment_decoder.sv
// Monitors a multiplexed active-low 8-digit seven-segment bus and rebuilds the
// displayed 32-bit hex value, one settled, legal digit capture at a time.
module seven_segment_decoder #(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [6:0]  cat_in,
    input  logic [7:0]  an_in,
    output logic [31:0] val_out,
    output logic        valid_out,
    output logic        err_out,
    output logic [7:0]  digit_mask_out,
    output logic [1:0]  dbg_state_out
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [15:0] SETTLE_MAX = 16'(SETTLE_CYCLES);
    localparam logic [15:0] SETTLE_M1  = 16'(SETTLE_CYCLES - 1);

    logic [7:0]  r_an_s1, r_an_s2;
    logic [6:0]  r_cat_s1, r_cat_s2;
    logic [15:0] r_count;
    state_t      r_state, w_next_state;
    logic [31:0] r_shadow, r_val;
    logic [7:0]  r_mask;
    logic        r_valid, r_err;

    logic        w_change, w_capture, w_blank, w_onehot, w_nib_ok;
    logic [7:0]  w_sel, w_mask_next;
    logic [6:0]  w_seg;
    logic [3:0]  w_nib;
    logic [2:0]  w_idx;
    logic [31:0] w_shadow_next;

    // Stage 1 differing from stage 2 means the synchronized bus changes on the next edge.
    assign w_change  = ({r_an_s1, r_cat_s1} != {r_an_s2, r_cat_s2});
    assign w_capture = (r_state == ST_SAMPLE) && !w_change;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_an_s1  <= 8'hFF;
            r_an_s2  <= 8'hFF;
            r_cat_s1 <= 7'h7F;
            r_cat_s2 <= 7'h7F;
            r_count  <= 16'd0;
            r_state  <= ST_WAIT;
        end else begin
            r_an_s1  <= an_in;
            r_an_s2  <= r_an_s1;
            r_cat_s1 <= cat_in;
            r_cat_s2 <= r_cat_s1;
            r_state  <= w_next_state;
            if (w_change) begin
                r_count <= 16'd0;
            end else if (r_count != SETTLE_MAX) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_WAIT:   if (!w_change && (r_count == SETTLE_M1)) w_next_state = ST_SAMPLE;
            ST_SAMPLE: w_next_state = w_change ? ST_WAIT : ST_DONE;
            ST_DONE:   if (w_change) w_next_state = ST_WAIT;
            default:   w_next_state = ST_WAIT;
        endcase
    end

    always_comb begin
        w_seg    = ~r_cat_s2;
        w_nib_ok = 1'b1;
        w_nib    = 4'h0;
        case (w_seg)
            7'h3F: w_nib = 4'h0;
            7'h06: w_nib = 4'h1;
            7'h5B: w_nib = 4'h2;
            7'h4F: w_nib = 4'h3;
            7'h66: w_nib = 4'h4;
            7'h6D: w_nib = 4'h5;
            7'h7D: w_nib = 4'h6;
            7'h07: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h6F: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h7C: w_nib = 4'hB;
            7'h39: w_nib = 4'hC;
            7'h5E: w_nib = 4'hD;
            7'h79: w_nib = 4'hE;
            7'h71: w_nib = 4'hF;
            default: w_nib_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_sel    = ~r_an_s2;
        w_blank  = (w_sel == 8'h00);
        w_onehot = $onehot(w_sel);
        w_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_sel[i]) w_idx = 3'(i);
        end
        w_shadow_next = r_shadow;
        w_shadow_next[{w_idx, 2'b00} +: 4] = w_nib;
        w_mask_next = r_mask | (8'h01 << w_idx);
    end

    // Frame completion writes val from the shadow including the nibble landing this edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_shadow <= 32'd0;
            r_val    <= 32'd0;
            r_mask   <= 8'd0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_capture && !w_blank) begin
                if (!w_onehot || !w_nib_ok) begin
                    r_err  <= 1'b1;
                    r_mask <= 8'd0;
                end else begin
                    r_shadow <= w_shadow_next;
                    if (w_mask_next == 8'hFF) begin
                        r_val   <= w_shadow_next;
                        r_valid <= 1'b1;
                        r_mask  <= 8'd0;
                    end else begin
                        r_mask <= w_mask_next;
                    end
                end
            end
        end
    end

    assign val_out        = r_val;
    assign valid_out      = r_valid;
    assign err_out        = r_err;
    assign digit_mask_out = r_mask;
    assign dbg_state_out  = r_state;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed bench for seven_segment_decoder: one instance at SETTLE_CYCLES=16 for
// frame/glitch/error/reset scenarios, one at SETTLE_CYCLES=1 for exact latency.
module tb_seven_segment_decoder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  an0, an1;
    logic [6:0]  cat0, cat1;
    logic [31:0] val0, val1;
    logic        valid0, valid1, err0, err1;
    logic [7:0]  mask0, mask1;
    logic [1:0]  dbg0, dbg1;

    int tests = 0;
    int fails = 0;
    int valid_cnt0 = 0, err_cnt0 = 0, valid_cnt1 = 0, err_cnt1 = 0;

    seven_segment_decoder #(.SETTLE_CYCLES(16)) dut0 (
        .clk_in(clk), .rst_in(rst_n), .cat_in(cat0), .an_in(an0),
        .val_out(val0), .valid_out(valid0), .err_out(err0),
        .digit_mask_out(mask0), .dbg_state_out(dbg0)
    );

    seven_segment_decoder #(.SETTLE_CYCLES(1)) dut1 (
        .clk_in(clk), .rst_in(rst_n), .cat_in(cat1), .an_in(an1),
        .val_out(val1), .valid_out(valid1), .err_out(err1),
        .digit_mask_out(mask1), .dbg_state_out(dbg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid0) valid_cnt0++;
        if (err0)   err_cnt0++;
        if (valid1) valid_cnt1++;
        if (err1)   err_cnt1++;
    end

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic [7:0] an, input logic [6:0] cat, input int dwell);
        @(negedge clk);
        if (which == 0) begin an0 = an; cat0 = cat; end
        else            begin an1 = an; cat1 = cat; end
        repeat (dwell - 1) @(negedge clk);
    endtask

    task automatic show(input int which, input int k, input logic [3:0] nib, input int dwell);
        drive(which, ~(8'h01 << k), ~seg(nib), dwell);
    endtask

    task automatic show_digits(input int which, input logic [31:0] value, input int lo, input int hi, input int dwell);
        for (int k = lo; k <= hi; k++) show(which, k, value[4*k +: 4], dwell);
    endtask

    task automatic blank(input int which, input int dwell);
        drive(which, 8'hFF, 7'h7F, dwell);
    endtask

    initial begin
        rst_n = 1'b0;
        an0 = 8'hFF; cat0 = 7'h7F; an1 = 8'hFF; cat1 = 7'h7F;
        repeat (3) @(negedge clk);
        check("reset_val",   val0, 32'h0);
        check("reset_valid", {31'd0, valid0}, 32'h0);
        check("reset_err",   {31'd0, err0}, 32'h0);
        check("reset_mask",  {24'd0, mask0}, 32'h0);
        rst_n = 1'b1;
        blank(0, 5);

        // Full frame.
        show_digits(0, 32'h1234ABCD, 0, 3, 50);
        check("frame1_partial_mask", {24'd0, mask0}, 32'h0000000F);
        show_digits(0, 32'h1234ABCD, 4, 7, 50);
        blank(0, 30);
        check("frame1_val",   val0, 32'h1234ABCD);
        check("frame1_valid", valid_cnt0, 1);
        check("frame1_err",   err_cnt0, 0);
        check("frame1_mask",  {24'd0, mask0}, 32'h0);

        // Anode glitch to digit 3 inside a digit-2 dwell.
        show(0, 2, 4'h2, 20);
        drive(0, 8'hF7, ~seg(4'h2), 5);
        show(0, 2, 4'h2, 50);
        check("glitch_mask", {24'd0, mask0}, 32'h00000004);
        check("glitch_err",  err_cnt0, 0);
        show_digits(0, 32'h76543210, 0, 1, 50);
        show_digits(0, 32'h76543210, 3, 7, 50);
        blank(0, 30);
        check("glitch_val",   val0, 32'h76543210);
        check("glitch_valid", valid_cnt0, 2);

        // Blank segments on a selected digit.
        show_digits(0, 32'h99995A5A, 0, 3, 50);
        check("illegal_pre_mask", {24'd0, mask0}, 32'h0000000F);
        drive(0, 8'hF7, 7'h7F, 30);
        check("illegal_err",  err_cnt0, 1);
        check("illegal_mask", {24'd0, mask0}, 32'h0);
        check("illegal_val",  val0, 32'h76543210);
        show_digits(0, 32'hFFFF0000, 0, 7, 50);
        blank(0, 30);
        check("after_illegal_val",   val0, 32'hFFFF0000);
        check("after_illegal_valid", valid_cnt0, 3);

        // Two anodes low at once.
        show_digits(0, 32'h00000021, 0, 1, 50);
        check("multihot_pre_mask", {24'd0, mask0}, 32'h00000003);
        drive(0, 8'hFC, ~seg(4'h0), 30);
        blank(0, 30);
        check("multihot_err",   err_cnt0, 2);
        check("multihot_mask",  {24'd0, mask0}, 32'h0);
        check("multihot_val",   val0, 32'hFFFF0000);
        check("multihot_valid", valid_cnt0, 3);

        // Asynchronous reset mid-frame.
        show_digits(0, 32'hCAFE0123, 0, 4, 50);
        check("midreset_pre_mask", {24'd0, mask0}, 32'h0000001F);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_val",  val0, 32'h0);
        check("midreset_mask", {24'd0, mask0}, 32'h0);
        an0 = 8'hFF; cat0 = 7'h7F;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        blank(0, 5);
        show_digits(0, 32'hCAFE0123, 5, 7, 50);
        blank(0, 30);
        check("postreset_partial_valid", valid_cnt0, 3);
        check("postreset_partial_val",   val0, 32'h0);
        check("postreset_partial_mask",  {24'd0, mask0}, 32'h000000E0);
        show_digits(0, 32'hCAFE0123, 0, 7, 50);
        blank(0, 30);
        check("postreset_val",   val0, 32'hCAFE0123);
        check("postreset_valid", valid_cnt0, 4);
        check("total_err0",      err_cnt0, 2);

        // Exact latency with SETTLE_CYCLES=1.
        @(negedge clk);
        an1 = 8'hFE; cat1 = ~seg(4'hA);
        @(posedge clk);  // E0
        @(posedge clk);
        @(posedge clk);
        #1 check("lat_mask_e0p2", {24'd0, mask1}, 32'h0);
        @(posedge clk);
        #1 check("lat_mask_e0p3", {24'd0, mask1}, 32'h00000001);
        repeat (5) @(negedge clk);
        show_digits(1, 32'h1234567A, 1, 6, 6);
        @(negedge clk);
        an1 = 8'h7F; cat1 = ~seg(4'h1);
        @(posedge clk);  // E0
        @(posedge clk);
        @(posedge clk);
        #1 check("lat_valid_e0p2", {31'd0, valid1}, 32'h0);
        @(posedge clk);
        #1 check("lat_valid_e0p3", {31'd0, valid1}, 32'h1);
        check("lat_val", val1, 32'h1234567A);
        @(posedge clk);
        #1 check("lat_valid_e0p4", {31'd0, valid1}, 32'h0);
        blank(1, 10);
        check("lat_valid_count", valid_cnt1, 1);
        check("lat_err_count",   err_cnt1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
